cmd_adr_cov_monitor: RTL
========================

Name: cmd_adr_cov_monitor

Overview:
- Synthesizable multi-channel successor to the per-interface cmd/adr sampler.
- Watches N_CH cmd/adr/data buses and records every unique (cmd,adr) pair in an on-chip bin bitmap.
- Keeps unique-bin and total-sample counters, and pulses when a new bin is first hit.
- Sits beside the DUT bus and is read back through a simple request/acknowledge port.

Parameters:
- CMD_W, 4, cmd field width.
- ADR_W, 4, adr field width.
- DATA_W, 4, data field width (carried for tracing; not binned).
- N_CH, 2, number of monitored channels, 1..8.
- CNT_W, 16, total-sample counter width.
- Derived: BIN_W = CMD_W+ADR_W, NBINS = 2**BIN_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_en  in  1  global sampling enable (the "weight" gate); 0 ignores all channels.
- clear  in  1  synchronous clear of bitmap, counters and pipeline.
- ch_valid  in  N_CH  per-channel sample strobe.
- ch_cmd  in  N_CH*CMD_W  channel i at bits [i*CMD_W +: CMD_W].
- ch_adr  in  N_CH*ADR_W  packed as for ch_cmd.
- ch_data  in  N_CH*DATA_W  packed as for ch_cmd; unused except last_data.
- rd_req  in  1  readback request.
- rd_bin  in  BIN_W  bin index {cmd,adr}, cmd in MSBs.
- rd_ack  out  1  readback response valid.
- rd_hit  out  1  bitmap value of rd_bin.
- unique_cnt  out  BIN_W+1  number of covered bins.
- total_cnt  out  CNT_W  accepted samples, saturating.
- all_covered  out  1  unique_cnt == NBINS.
- new_bin  out  1  one-cycle pulse: at least one bin newly covered.
- new_bin_id  out  BIN_W  lowest-index channel's newly covered bin.
- last_data  out  DATA_W  data of the highest-index accepted channel.

Behaviour:
- Reset (rst_n=0, asynchronous): bitmap all 0 and stage-1 registers invalid. All outputs 0: rd_ack, rd_hit, unique_cnt, total_cnt, all_covered, new_bin, new_bin_id, last_data.
- Stage 1, edge N: a channel is accepted iff ch_valid[i] && sample_en. The accepted valid mask, bin = {cmd,adr} and data are registered per channel.
- Stage 2, edge N+1: bitmap bits for the stage-1 bins are set and counters update.
  - A sample presented at edge N is visible on unique_cnt, total_cnt, new_bin and rd_hit after edge N+1.
- Same-cycle duplicates:
  - Several channels hitting one uncovered bin increment unique_cnt by 1.
  - Channels hitting distinct uncovered bins increment unique_cnt by the number of distinct new bins.
  - Hits on already-covered bins add 0.
- Stage-2 hazard: a stage-2 bin equal to a bin being committed in the same edge sees the pre-edge bitmap, and the in-cycle de-duplication handles it. Back-to-back samples of the same bin count once.
- total_cnt: adds popcount of the stage-1 valid mask each stage-2 edge and saturates at 2**CNT_W-1 (no wrap).
- new_bin: 1 for exactly the cycle after a stage-2 commit that covered at least one new bin, else 0. new_bin_id holds its value when new_bin=0.
- all_covered: combinational from unique_cnt. Sampling continues after full coverage; total_cnt still counts.
- last_data: updated only on stage-2 edges with at least one valid channel.
- Readback:
  - rd_req sampled at edge M gives rd_ack=1 and rd_hit=bitmap[rd_bin] after edge M.
  - The bitmap value is the value before any stage-2 commit at edge M.
  - rd_ack is 0 in cycles without a request; back-to-back requests give back-to-back acks.
  - rd_req is independent of sample_en.
- clear at edge K:
  - Bitmap, unique_cnt, total_cnt, new_bin and the stage-1 valids are zeroed.
  - Samples presented at edge K are dropped, and stage-1 contents are discarded.
  - clear has priority over every other update.
  - A read at edge K returns rd_ack=1, rd_hit=0.
- sample_en falling: samples already in stage 1 still commit.
- Reset mid-operation returns to the reset state immediately; no partial commits.

Test Plan:
- Reset then no stimulus -> all outputs 0; a read of any bin gives rd_ack=1, rd_hit=0.
- ch0 cmd=3 adr=5 at edge 1, sample_en=1 -> after edge 2: unique_cnt=1, total_cnt=1, new_bin=1 for one cycle, new_bin_id=0x35. A read of 0x35 returns rd_hit=1; a read of 0x36 returns 0.
- ch0 and ch1 both cmd=3 adr=5 in one cycle, then the same again -> unique_cnt=1, total_cnt=4, one new_bin pulse only.
- sample_en=0 with ch_valid=2'b11 for 10 cycles -> counters stay 0; then 256 distinct bins over 128 cycles on 2 channels -> unique_cnt=256, all_covered=1.
- Force total_cnt to 16'hFFFE, then 2 channels valid -> total_cnt=16'hFFFF and it holds on further samples.
- clear asserted on the same edge as a new sample, and separately rst_n pulsed low mid-stream -> counters and bitmap read 0; the cleared-edge sample never appears; new_bin stays 0.

Source files
------------

// File: rtl/cmd_adr_cov_if.sv
// Bus bundle for the cmd/adr coverage monitor: observed channels, control,
// readback port and coverage status.
//
// Handshake: rd_req is a single-cycle request with no backpressure. Every
// cycle rd_req is high at a rising edge produces rd_ack=1 with rd_hit valid
// in the cycle after that edge. Back-to-back requests get back-to-back acks.
interface cmd_adr_cov_if #(
  parameter int CMD_W  = 4,
  parameter int ADR_W  = 4,
  parameter int DATA_W = 4,
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16
);
  localparam int BIN_W = CMD_W + ADR_W;

  logic                     sample_en;
  logic                     clear;
  logic [N_CH-1:0]          ch_valid;
  logic [N_CH*CMD_W-1:0]    ch_cmd;
  logic [N_CH*ADR_W-1:0]    ch_adr;
  logic [N_CH*DATA_W-1:0]   ch_data;
  logic                     rd_req;
  logic [BIN_W-1:0]         rd_bin;
  logic                     rd_ack;
  logic                     rd_hit;
  logic [BIN_W:0]           unique_cnt;
  logic [CNT_W-1:0]         total_cnt;
  logic                     all_covered;
  logic                     new_bin;
  logic [BIN_W-1:0]         new_bin_id;
  logic [DATA_W-1:0]        last_data;

  modport master (
    output sample_en, clear, ch_valid, ch_cmd, ch_adr, ch_data, rd_req, rd_bin,
    input  rd_ack, rd_hit, unique_cnt, total_cnt, all_covered, new_bin,
           new_bin_id, last_data
  );

  modport slave (
    input  sample_en, clear, ch_valid, ch_cmd, ch_adr, ch_data, rd_req, rd_bin,
    output rd_ack, rd_hit, unique_cnt, total_cnt, all_covered, new_bin,
           new_bin_id, last_data
  );
endinterface

// File: rtl/cmd_adr_cov_monitor.sv
// Multi-channel cmd/adr coverage monitor. Stage 1 registers accepted samples,
// stage 2 sets bitmap bits and updates the unique/total counters. A readback
// port returns the bitmap bit of any bin one cycle after the request.
module cmd_adr_cov_monitor #(
  parameter int CMD_W  = 4,
  parameter int ADR_W  = 4,
  parameter int DATA_W = 4,
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst_n,
  cmd_adr_cov_if.slave bus
);
  localparam int BIN_W = CMD_W + ADR_W;
  localparam int NBINS = 2 ** BIN_W;

  logic [N_CH-1:0]              s1_valid_q, s1_valid_d;
  logic [N_CH-1:0][BIN_W-1:0]   s1_bin_q, s1_bin_d;
  logic [N_CH-1:0][DATA_W-1:0]  s1_data_q, s1_data_d;
  logic [NBINS-1:0]             bitmap_q, bitmap_d;
  logic [BIN_W:0]               unique_cnt_q, unique_cnt_d;
  logic [CNT_W-1:0]             total_cnt_q, total_cnt_d;
  logic                         new_bin_q, new_bin_d;
  logic [BIN_W-1:0]             new_bin_id_q, new_bin_id_d;
  logic [DATA_W-1:0]            last_data_q, last_data_d;
  logic                         rd_ack_q, rd_ack_d;
  logic                         rd_hit_q, rd_hit_d;

  // fresh[i]: channel i covers a bin absent from the bitmap and not already
  // claimed by a lower-index channel in the same commit.
  logic [N_CH-1:0]              fresh;
  logic [BIN_W:0]               fresh_cnt;
  logic [CNT_W:0]               sample_cnt;
  logic [CNT_W:0]               total_sum;

  // Stage 1: capture accepted channels; clear drops the samples of this edge.
  always_comb begin
    s1_valid_d = '0;
    s1_bin_d   = s1_bin_q;
    s1_data_d  = s1_data_q;
    for (int i = 0; i < N_CH; i++) begin
      s1_valid_d[i] = bus.ch_valid[i] & bus.sample_en & ~bus.clear;
      s1_bin_d[i]   = {bus.ch_cmd[i*CMD_W +: CMD_W], bus.ch_adr[i*ADR_W +: ADR_W]};
      s1_data_d[i]  = bus.ch_data[i*DATA_W +: DATA_W];
    end
  end

  // In-cycle de-duplication against the pre-edge bitmap and lower channels.
  always_comb begin
    fresh      = '0;
    fresh_cnt  = '0;
    sample_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      fresh[i] = s1_valid_q[i] & ~bitmap_q[s1_bin_q[i]];
      for (int j = 0; j < i; j++) begin
        if (s1_valid_q[j] && (s1_bin_q[j] == s1_bin_q[i])) fresh[i] = 1'b0;
      end
      fresh_cnt  = fresh_cnt + (BIN_W+1)'(fresh[i]);
      sample_cnt = sample_cnt + (CNT_W+1)'(s1_valid_q[i]);
    end
    total_sum = {1'b0, total_cnt_q} + sample_cnt;
  end

  // Stage 2: commit bitmap bits and counters; clear overrides everything.
  always_comb begin
    bitmap_d     = bitmap_q;
    unique_cnt_d = unique_cnt_q;
    total_cnt_d  = total_cnt_q;
    new_bin_d    = 1'b0;
    new_bin_id_d = new_bin_id_q;
    last_data_d  = last_data_q;
    if (bus.clear) begin
      bitmap_d     = '0;
      unique_cnt_d = '0;
      total_cnt_d  = '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (s1_valid_q[i]) begin
          bitmap_d[s1_bin_q[i]] = 1'b1;
          last_data_d           = s1_data_q[i];
        end
      end
      // Descending scan so the lowest-index fresh channel wins.
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (fresh[i]) new_bin_id_d = s1_bin_q[i];
      end
      unique_cnt_d = unique_cnt_q + fresh_cnt;
      new_bin_d    = |fresh;
      total_cnt_d  = total_sum[CNT_W] ? {CNT_W{1'b1}} : total_sum[CNT_W-1:0];
    end
  end

  // Readback sees the bitmap before this edge's commit; clear forces a miss.
  always_comb begin
    rd_ack_d = bus.rd_req;
    rd_hit_d = bus.rd_req & ~bus.clear & bitmap_q[bus.rd_bin];
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= '0;
      s1_bin_q     <= '0;
      s1_data_q    <= '0;
      bitmap_q     <= '0;
      unique_cnt_q <= '0;
      total_cnt_q  <= '0;
      new_bin_q    <= 1'b0;
      new_bin_id_q <= '0;
      last_data_q  <= '0;
      rd_ack_q     <= 1'b0;
      rd_hit_q     <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_bin_q     <= s1_bin_d;
      s1_data_q    <= s1_data_d;
      bitmap_q     <= bitmap_d;
      unique_cnt_q <= unique_cnt_d;
      total_cnt_q  <= total_cnt_d;
      new_bin_q    <= new_bin_d;
      new_bin_id_q <= new_bin_id_d;
      last_data_q  <= last_data_d;
      rd_ack_q     <= rd_ack_d;
      rd_hit_q     <= rd_hit_d;
    end
  end

  assign bus.rd_ack      = rd_ack_q;
  assign bus.rd_hit      = rd_hit_q;
  assign bus.unique_cnt  = unique_cnt_q;
  assign bus.total_cnt   = total_cnt_q;
  assign bus.all_covered = (unique_cnt_q == (BIN_W+1)'(NBINS));
  assign bus.new_bin     = new_bin_q;
  assign bus.new_bin_id  = new_bin_id_q;
  assign bus.last_data   = last_data_q;
endmodule
